shell_arbiter: RTL and testbench

- Shares a fixed pool of shell (projectile) slots between the two tank players.
- Turns each player's fire request into at most one spawn grant per frame, enforcing per-player cooldown and an ammo quota.
- Tracks each slot's owner and remaining lifetime, and retires slots on expiry or hit.
- Sits between the keycode decode / tank position logic and the shell motion datapath, clocked by the frame clock.

---
 rtl/tank_pkg.sv | 16 +
 rtl/shell_slot.sv | 44 ++++
 rtl/shell_arbiter.sv | 140 ++++++++++++++
 tb/tb_shell_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and default sizing for the tank shell arbitration logic.
package tank_pkg;

  typedef enum logic {
    PLAYER1 = 1'b0,
    PLAYER2 = 1'b1
  } player_t;

  typedef logic [9:0] cnt10_t;

  localparam int DEF_NUM_SHELLS     = 4;
  localparam int DEF_MAX_PER_PLAYER = 2;
  localparam int DEF_COOLDOWN       = 30;
  localparam int DEF_LIFETIME       = 120;

endpackage

// File: rtl/shell_slot.sv
// One shell slot: live flag, owner and lifetime countdown; retires on expiry or hit.
module shell_slot
  import tank_pkg::*;
#(
  parameter int LIFETIME = DEF_LIFETIME
) (
  input  logic frame_clk,
  input  logic Reset_n,
  input  logic i_alloc,
  input  logic i_owner,
  input  logic i_hit,
  output logic o_active,
  output logic o_owner
);

  logic   r_active;
  logic   r_owner;
  cnt10_t r_life;

  // The last decrement (1 -> 0) retires the slot on the same edge, so a
  // shell is live for exactly LIFETIME cycles.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_active <= 1'b0;
      r_owner  <= 1'b0;
      r_life   <= '0;
    end else if (i_alloc && !r_active) begin
      r_active <= 1'b1;
      r_owner  <= i_owner;
      r_life   <= cnt10_t'(LIFETIME);
    end else if (r_active) begin
      if (i_hit || r_life <= 10'd1) begin
        r_active <= 1'b0;
        r_life   <= '0;
      end else begin
        r_life <= r_life - 10'd1;
      end
    end
  end

  assign o_active = r_active;
  assign o_owner  = r_owner;

endmodule

// File: rtl/shell_arbiter.sv
// Shares NUM_SHELLS shell slots between two players with cooldown, quota and
// alternating priority. Define SHELL_ARB_AUTOFIRE_EN for level-sensitive (held key) fire.
module shell_arbiter
  import tank_pkg::*;
#(
  parameter int NUM_SHELLS     = DEF_NUM_SHELLS,
  parameter int MAX_PER_PLAYER = DEF_MAX_PER_PLAYER,
  parameter int COOLDOWN       = DEF_COOLDOWN,
  parameter int LIFETIME       = DEF_LIFETIME,
  localparam int IW            = $clog2(NUM_SHELLS)
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic [1:0]            fire_req,
  input  logic [NUM_SHELLS-1:0] hit,
  output logic [NUM_SHELLS-1:0] slot_active,
  output logic [NUM_SHELLS-1:0] slot_owner,
  output logic                  spawn_valid,
  output logic [IW-1:0]         spawn_slot,
  output logic                  spawn_owner,
  output logic [1:0]            deny,
  output logic [1:0]            cooldown_busy
);

  logic [1:0]    r_fire_q;
  logic [1:0]    r_pending;
  logic [1:0]    r_deny;
  cnt10_t        r_cool [2];
  player_t       r_prio;
  logic          r_spawn_valid;
  logic [IW-1:0] r_spawn_slot;
  logic          r_spawn_owner;

  logic                  w_any_free;
  logic [IW-1:0]         w_free_idx;
  logic [3:0]            w_owned [2];
  logic [1:0]            w_ok;
  logic [1:0]            w_elig;
  logic [1:0]            w_cand;
  logic                  w_grant;
  player_t               w_win;
  logic [1:0]            w_grant_vec;
  logic [1:0]            w_drop;
  logic [1:0]            w_deny;
  logic [1:0]            w_set;
  logic [NUM_SHELLS-1:0] w_alloc;

  assign w_any_free = ~&slot_active;

  always_comb begin
    w_free_idx = '0;
    w_owned[0] = '0;
    w_owned[1] = '0;
    for (int i = NUM_SHELLS - 1; i >= 0; i--) begin
      if (!slot_active[i]) w_free_idx = IW'(i);
    end
    for (int i = 0; i < NUM_SHELLS; i++) begin
      if (slot_active[i]) begin
        if (slot_owner[i]) w_owned[1] = w_owned[1] + 4'd1;
        else               w_owned[0] = w_owned[0] + 4'd1;
      end
    end
  end

  always_comb begin
    w_win       = PLAYER1;
    w_grant_vec = '0;
    w_alloc     = '0;
    for (int p = 0; p < 2; p++) begin
      w_ok[p] = (r_cool[p] == '0) && (w_owned[p] < 4'(MAX_PER_PLAYER));
    end
    w_elig  = w_ok & {2{w_any_free}};
    w_cand  = r_pending & w_elig;
    w_grant = |w_cand;
    if (&w_cand)        w_win = r_prio;
    else if (w_cand[1]) w_win = PLAYER2;
    if (w_grant) begin
      w_grant_vec[0] = (w_win == PLAYER1);
      w_grant_vec[1] = (w_win == PLAYER2);
    end
    for (int i = 0; i < NUM_SHELLS; i++) begin
      w_alloc[i] = w_grant && (w_free_idx == IW'(i));
    end
    // Ineligible pending requests are dropped; a losing eligible one is kept.
    w_drop = r_pending & ~w_elig;
`ifdef SHELL_ARB_AUTOFIRE_EN
    w_set  = fire_req;
    w_deny = (r_pending & ~w_ok & ~fire_req) | (r_pending & w_ok & {2{~w_any_free}});
`else
    w_set  = fire_req & ~r_fire_q;
    w_deny = w_drop;
`endif
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fire_q      <= '0;
      r_pending     <= '0;
      r_deny        <= '0;
      r_cool[0]     <= '0;
      r_cool[1]     <= '0;
      r_prio        <= PLAYER1;
      r_spawn_valid <= 1'b0;
      r_spawn_slot  <= '0;
      r_spawn_owner <= 1'b0;
    end else begin
      r_fire_q      <= fire_req;
      r_pending     <= (r_pending & ~w_drop & ~w_grant_vec) | w_set;
      r_deny        <= w_deny;
      r_spawn_valid <= w_grant;
      r_spawn_slot  <= w_grant ? w_free_idx : '0;
      r_spawn_owner <= w_grant ? logic'(w_win) : 1'b0;
      if (w_grant) r_prio <= (w_win == PLAYER1) ? PLAYER2 : PLAYER1;
      for (int p = 0; p < 2; p++) begin
        if (w_grant_vec[p])       r_cool[p] <= cnt10_t'(COOLDOWN);
        else if (r_cool[p] != '0) r_cool[p] <= r_cool[p] - 10'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SHELLS; g++) begin : g_slot
    shell_slot #(.LIFETIME(LIFETIME)) u_slot (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .i_alloc   (w_alloc[g]),
      .i_owner   (logic'(w_win)),
      .i_hit     (hit[g]),
      .o_active  (slot_active[g]),
      .o_owner   (slot_owner[g])
    );
  end

  assign spawn_valid      = r_spawn_valid;
  assign spawn_slot       = r_spawn_slot;
  assign spawn_owner      = r_spawn_owner;
  assign deny             = r_deny;
  assign cooldown_busy[0] = (r_cool[0] != '0);
  assign cooldown_busy[1] = (r_cool[1] != '0);

endmodule

// File: tb/tb_shell_arbiter.sv
// Directed bench for shell_arbiter with default parameters (4 slots, quota 2,
// cooldown 30, lifetime 120); expected values are worked out by hand per step.
module tb_shell_arbiter;

  logic       frame_clk;
  logic       Reset_n;
  logic [1:0] fire_req;
  logic [3:0] hit;
  logic [3:0] slot_active;
  logic [3:0] slot_owner;
  logic       spawn_valid;
  logic [1:0] spawn_slot;
  logic       spawn_owner;
  logic [1:0] deny;
  logic [1:0] cooldown_busy;

  int n_checks;
  int n_errors;

  shell_arbiter dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .fire_req      (fire_req),
    .hit           (hit),
    .slot_active   (slot_active),
    .slot_owner    (slot_owner),
    .spawn_valid   (spawn_valid),
    .spawn_slot    (spawn_slot),
    .spawn_owner   (spawn_owner),
    .deny          (deny),
    .cooldown_busy (cooldown_busy)
  );

  // clock / reset
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    fire_req = '0;
    hit      = '0;
    Reset_n  = 1'b0;
    #2;
    Reset_n  = 1'b1;
    tick();
  endtask

  // Rising edge sampled on the first edge; arbitration result visible after the second.
  task automatic press(input logic [1:0] p);
    fire_req = p;
    tick();
    fire_req = '0;
    tick();
  endtask

  task automatic pulse_hit(input logic [3:0] h);
    hit = h;
    tick();
    hit = '0;
  endtask

  task automatic expect_spawn(input string tag, input logic [1:0] slot, input logic owner);
    check({tag, "_valid"}, 32'(spawn_valid), 32'd1);
    check({tag, "_slot"},  32'(spawn_slot),  32'(slot));
    check({tag, "_owner"}, 32'(spawn_owner), 32'(owner));
  endtask

  initial begin
    int n_sp;
    int n_dn;
    n_checks = 0;
    n_errors = 0;
    Reset_n  = 1'b0;
    fire_req = '0;
    hit      = '0;
    repeat (3) @(posedge frame_clk);
    #1;
    check("rst_active", 32'(slot_active),   32'h0);
    check("rst_spawn",  32'(spawn_valid),   32'h0);
    check("rst_deny",   32'(deny),          32'h0);
    check("rst_busy",   32'(cooldown_busy), 32'h0);
    Reset_n = 1'b1;
    tick();

    // single spawn and exact lifetime
    press(2'b01);
    expect_spawn("t1_spawn", 2'd0, 1'b0);
    check("t1_active", 32'(slot_active),   32'h1);
    check("t1_busy",   32'(cooldown_busy), 32'h1);
    wait_ticks(119);
    check("t1_pulse_one_cycle", 32'(spawn_valid),    32'h0);
    check("t1_life_last",       32'(slot_active[0]), 32'h1);
    tick();
    check("t1_expired",         32'(slot_active[0]), 32'h0);

    // cooldown deny, then exact cooldown release
    do_reset();
    press(2'b01);
    expect_spawn("t2_first", 2'd0, 1'b0);
    wait_ticks(3);
    press(2'b01);
    check("t2_cool_deny",   32'(deny),        32'h1);
    check("t2_cool_nospwn", 32'(spawn_valid), 32'h0);
    tick();
    check("t2_deny_pulse",  32'(deny),        32'h0);
    wait_ticks(23);
    check("t2_busy_last",   32'(cooldown_busy), 32'h1);
    tick();
    check("t2_busy_clear",  32'(cooldown_busy), 32'h0);
    press(2'b01);
    expect_spawn("t2_second", 2'd1, 1'b0);
    check("t2_active", 32'(slot_active), 32'h3);

    // quota deny, hit frees lowest slot, hit on idle slot ignored
    wait_ticks(30);
    press(2'b01);
    check("t4_quota_deny",   32'(deny),        32'h1);
    check("t4_quota_nospwn", 32'(spawn_valid), 32'h0);
    pulse_hit(4'b0001);
    check("t4_hit_clear", 32'(slot_active), 32'h2);
    press(2'b01);
    expect_spawn("t4_refill", 2'd0, 1'b0);
    pulse_hit(4'b0100);
    check("t4_hit_idle", 32'(slot_active), 32'h3);

    // simultaneous requests and alternating priority
    do_reset();
    press(2'b11);
    expect_spawn("t3_p1_first", 2'd0, 1'b0);
    check("t3_loser_nodeny", 32'(deny), 32'h0);
    tick();
    expect_spawn("t3_p2_second", 2'd1, 1'b1);
    check("t3_deny2",  32'(deny),            32'h0);
    check("t3_active", 32'(slot_active),     32'h3);
    check("t3_owner",  32'(slot_owner[1:0]), 32'h2);
    pulse_hit(4'b0011);
    check("t3_cleared", 32'(slot_active), 32'h0);
    wait_ticks(30);
    press(2'b01);
    expect_spawn("t3_p1_alone", 2'd0, 1'b0);
    wait_ticks(30);
    press(2'b11);
    expect_spawn("t3_p2_wins", 2'd1, 1'b1);
    tick();
    expect_spawn("t3_p1_next", 2'd2, 1'b0);
    check("t3_active2", 32'(slot_active),     32'h7);
    check("t3_owner2",  32'(slot_owner[2:0]), 32'h2);

    // full pool, and hit coinciding with request evaluation
    wait_ticks(28);
    press(2'b10);
    expect_spawn("t5_fill", 2'd3, 1'b1);
    check("t5_full", 32'(slot_active), 32'hf);
    wait_ticks(28);
    press(2'b10);
    check("t5_full_deny", 32'(deny), 32'h2);
    fire_req = 2'b01;
    tick();
    fire_req = '0;
    hit      = 4'b0100;
    tick();
    hit      = '0;
    check("t5_same_cycle_deny",  32'(deny),        32'h1);
    check("t5_same_cycle_nospw", 32'(spawn_valid), 32'h0);
    check("t5_slot2_freed",      32'(slot_active), 32'hb);
    press(2'b01);
    expect_spawn("t5_reuse2", 2'd2, 1'b0);

    // asynchronous reset with three live shells
    pulse_hit(4'b1000);
    check("t6_three_live", 32'(slot_active),   32'h7);
    check("t6_pre_busy",   32'(cooldown_busy), 32'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t6_async_active", 32'(slot_active),   32'h0);
    check("t6_async_busy",   32'(cooldown_busy), 32'h0);
    Reset_n = 1'b1;
    tick();

    // held key
    n_sp = 0;
    n_dn = 0;
    fire_req = 2'b01;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (spawn_valid) n_sp++;
      if (deny != 2'b00) n_dn++;
    end
    fire_req = '0;
`ifdef SHELL_ARB_AUTOFIRE_EN
    check("t7_hold_spawns", 32'(n_sp), 32'd2);
`else
    check("t7_hold_spawns", 32'(n_sp), 32'd1);
`endif
    check("t7_hold_denies", 32'(n_dn), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
